// File: rtl/note_sequencer_pkg.sv
// rtl/note_sequencer_pkg.sv - shared constants for the note sequencer
package note_sequencer_pkg;

  // FSM state encoding, kept as plain 3-bit constants so older code can reuse it
  typedef logic [2:0] state_t;

  localparam int     STATE_W  = 3;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_LOAD  = 3'd2;
  localparam state_t ST_PLAY  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // A ROM entry with this duration terminates the song
  localparam int END_OF_SONG_DUR = 0;

  // Note code that means silence
  localparam int REST_NOTE = 0;

endpackage

// File: rtl/note_sequencer_dffr.sv
// rtl/note_sequencer_dffr.sv - resettable register used for every sequencer flop
module note_sequencer_dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Synchronous active-high clear, otherwise capture d
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - walks a song ROM and plays each note for its beat count
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              restart,
  input  logic              beat,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0] rom_note,
  input  logic [DUR_W-1:0]  rom_dur,
  output logic [NOTE_W-1:0] note_out,
  output logic              new_note,
  output logic              song_done
);

  localparam logic [DUR_W-1:0]  END_DUR   = DUR_W'(END_OF_SONG_DUR);
  localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);
  localparam logic [NOTE_W-1:0] SILENCE   = NOTE_W'(REST_NOTE);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t              state;
  state_t              state_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DUR_W-1:0]    dur_cnt;
  logic [DUR_W-1:0]    dur_n;
  logic [NOTE_W-1:0]   note_n;
  logic                new_n;

  note_sequencer_dffr #(.W(STATE_W)) u_state_reg (
    .clk (clk),
    .rst (rst),
    .d   (state_n),
    .q   (state)
  );

  note_sequencer_dffr #(.W(ADDR_W)) u_addr_reg (
    .clk (clk),
    .rst (rst),
    .d   (addr_n),
    .q   (rom_addr)
  );

  note_sequencer_dffr #(.W(DUR_W)) u_dur_reg (
    .clk (clk),
    .rst (rst),
    .d   (dur_n),
    .q   (dur_cnt)
  );

  note_sequencer_dffr #(.W(NOTE_W)) u_note_reg (
    .clk (clk),
    .rst (rst),
    .d   (note_n),
    .q   (note_out)
  );

  note_sequencer_dffr #(.W(1)) u_new_reg (
    .clk (clk),
    .rst (rst),
    .d   (new_n),
    .q   (new_note)
  );

  assign song_done = (state == ST_DONE);

  // Next-state logic: restart rewinds first, then the FSM walks the song
  always_comb begin
    state_n = state;
    addr_n  = rom_addr;
    dur_n   = dur_cnt;
    note_n  = note_out;
    new_n   = 1'b0;

    if (restart) begin
      state_n = ST_IDLE;
      addr_n  = '0;
      dur_n   = '0;
      note_n  = SILENCE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (play) begin
            state_n = ST_FETCH;
          end
        end

        // One idle cycle so the synchronous ROM can present the addressed entry
        ST_FETCH: begin
          state_n = ST_LOAD;
        end

        ST_LOAD: begin
          if (rom_dur == END_DUR) begin
            state_n = ST_DONE;
            note_n  = SILENCE;
          end else begin
            state_n = ST_PLAY;
            note_n  = rom_note;
            dur_n   = rom_dur;
            new_n   = 1'b1;
          end
        end

        // Only beats seen while playing count; a pause simply holds everything
        ST_PLAY: begin
          if (beat && play) begin
            if (dur_cnt <= DUR_ONE) begin
              if (rom_addr == ADDR_LAST) begin
                state_n = ST_DONE;
                note_n  = SILENCE;
              end else begin
                state_n = ST_FETCH;
                addr_n  = rom_addr + ADDR_ONE;
              end
            end else begin
              dur_n = dur_cnt - DUR_ONE;
            end
          end
        end

        ST_DONE: begin
          note_n = SILENCE;
        end

        default: begin
          state_n = ST_IDLE;
          addr_n  = '0;
          dur_n   = '0;
          note_n  = SILENCE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - scoreboard bench for the note sequencer
module tb_note_sequencer;

  localparam int ADDR_W = 5;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int DEPTH  = 32;

  logic              clk;
  logic              rst;
  logic              play;
  logic              restart;
  logic              beat;
  logic [ADDR_W-1:0] rom_addr;
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;
  logic [NOTE_W-1:0] note_out;
  logic              new_note;
  logic              song_done;

  note_sequencer #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .play      (play),
    .restart   (restart),
    .beat      (beat),
    .rom_addr  (rom_addr),
    .rom_note  (rom_note),
    .rom_dur   (rom_dur),
    .note_out  (note_out),
    .new_note  (new_note),
    .song_done (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Song ROM with one cycle of read latency
  logic [NOTE_W-1:0] mem_note [DEPTH];
  logic [DUR_W-1:0]  mem_dur  [DEPTH];
  always @(posedge clk) begin
    rom_note <= mem_note[rom_addr];
    rom_dur  <= mem_dur[rom_addr];
  end

  typedef struct {
    bit              is_done;
    logic [NOTE_W-1:0] note;
    int              dur;
    int              gap;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;

  bit              mon_en;
  int              mon_cyc;
  int              ref_cyc;
  bit              in_note;
  bit              started;
  bit              prev_done;
  logic [NOTE_W-1:0] cur_note;
  int              cur_dur;
  int              beats_cnt;

  function automatic void check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endfunction

  // Song-level model: each entry plays for dur counted beats; the next event
  // appears 3 cycles after the terminating beat (fetch, load), or 1 cycle when
  // the last ROM slot ends the song directly.
  function automatic int build_expect();
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_dur[i] == 0) begin
        e = '{is_done: 1'b1, note: '0, dur: 0, gap: 3};
        exp_q.push_back(e);
        return i;
      end
      e = '{is_done: 1'b0, note: mem_note[i], dur: int'(mem_dur[i]), gap: 3};
      exp_q.push_back(e);
    end
    e = '{is_done: 1'b1, note: '0, dur: 0, gap: 1};
    exp_q.push_back(e);
    return DEPTH - 1;
  endfunction

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        started   = 1'b0;
        in_note   = 1'b0;
        prev_done = 1'b0;
        mon_cyc   = 0;
        ref_cyc   = 0;
      end else begin
        mon_cyc++;
        if (new_note || (song_done && !prev_done)) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("event_kind", song_done, e.is_done);
            check("event_note", note_out, e.is_done ? 0 : e.note);
            check("event_gap", mon_cyc - ref_cyc, e.gap);
            in_note   = new_note && !e.is_done;
            cur_note  = note_out;
            cur_dur   = e.dur;
            beats_cnt = 0;
          end
        end else if (in_note) begin
          check("note_hold", note_out, cur_note);
        end
        if (!started && play) begin
          started = 1'b1;
          ref_cyc = mon_cyc;
        end
        if (in_note && beat && play) begin
          beats_cnt++;
          if (beats_cnt == cur_dur) begin
            in_note = 1'b0;
            ref_cyc = mon_cyc;
          end
        end
        prev_done = song_done;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; play = 1'b0; beat = 1'b0; restart = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // period>0: beat every period cycles, else random beats
  task automatic run_song(input int period, input int pause_len, input int play_pct);
    int  last_idx;
    int  n_exp;
    bit  paused;
    bit  finished;
    do_reset();
    last_idx = build_expect();
    n_exp    = exp_q.size();
    paused   = 1'b0;
    finished = 1'b0;
    mon_en   = 1'b1;
    @(posedge clk); #1;
    play = 1'b1;
    for (int i = 1; i < 8000 && !finished; i++) begin
      @(posedge clk); #1;
      beat = (period > 0) ? ((i % period) == 0) : ($urandom_range(0, 2) == 0);
      if (exp_q.size() < n_exp) play = ($urandom_range(0, 99) < play_pct);
      if (pause_len > 0 && !paused && in_note && beats_cnt == 1) begin
        play = 1'b0;
        for (int k = 0; k < pause_len; k++) begin
          @(posedge clk); #1;
          beat = ((k % 7) == 0);
        end
        play   = 1'b1;
        paused = 1'b1;
      end
      if (exp_q.size() == 0 && song_done) finished = 1'b1;
    end
    check("run_finished", finished, 1);
    beat = 1'b0;
    play = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    check("queue_empty", exp_q.size(), 0);
    check("final_done", song_done, 1);
    check("final_note", note_out, 0);
    check("final_addr", rom_addr, last_idx);
  endtask

  task automatic wait_new_note(input int max_edges, output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!new_note && edges < max_edges);
  endtask

  initial begin
    int edges;
    total = 0; bad = 0; mon_en = 1'b0;
    rst = 1'b1; play = 1'b0; restart = 1'b0; beat = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_note[i] = '0;
      mem_dur[i]  = '0;
    end
    fork
      monitor_loop();
    join_none

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_addr", rom_addr, 0);
    check("rst_note", note_out, 0);
    check("rst_new", new_note, 0);
    check("rst_done", song_done, 0);

    // Three-entry song with beats every 32 cycles
    mem_note[0] = 6'd5; mem_dur[0] = 6'd2;
    mem_note[1] = 6'd9; mem_dur[1] = 6'd1;
    mem_note[2] = 6'd0; mem_dur[2] = 6'd0;
    run_song(32, 0, 100);

    // Long pause in the middle of a three-beat note
    mem_note[0] = 6'd12; mem_dur[0] = 6'd3;
    mem_note[1] = 6'd33; mem_dur[1] = 6'd2;
    mem_note[2] = 6'd0;  mem_dur[2] = 6'd0;
    run_song(5, 100, 100);

    // Every slot one beat long, no end marker: stop at the last address
    for (int i = 0; i < DEPTH; i++) begin
      mem_note[i] = NOTE_W'(i + 1);
      mem_dur[i]  = 6'd1;
    end
    run_song(4, 0, 100);

    // Dense beats so many land while fetching and loading
    run_song(2, 0, 100);

    // Restart coinciding with the note-ending beat
    mem_note[0] = 6'd4; mem_dur[0] = 6'd1;
    mem_note[1] = 6'd7; mem_dur[1] = 6'd1;
    mem_note[2] = 6'd0; mem_dur[2] = 6'd0;
    do_reset();
    play = 1'b1;
    wait_new_note(20, edges);
    check("rs_first_note_seen", new_note, 1);
    check("rs_first_latency", edges, 3);
    check("rs_first_value", note_out, 4);
    beat = 1'b1; restart = 1'b1;
    @(posedge clk); #1;
    beat = 1'b0; restart = 1'b0; play = 1'b0;
    check("rs_addr", rom_addr, 0);
    check("rs_note", note_out, 0);
    check("rs_done", song_done, 0);
    repeat (5) @(posedge clk);
    #1;
    check("rs_idle_addr", rom_addr, 0);
    check("rs_idle_new", new_note, 0);
    play = 1'b1;
    wait_new_note(20, edges);
    check("rs_replay_latency", edges, 3);
    check("rs_replay_value", note_out, 4);
    play = 1'b0;

    // Reset in the middle of a note at address 7
    for (int i = 0; i < DEPTH; i++) begin
      mem_note[i] = NOTE_W'(i + 1);
      mem_dur[i]  = 6'd2;
    end
    do_reset();
    play = 1'b1;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
      beat = ((edges % 3) == 0);
    end while (!(new_note && rom_addr == 7) && edges < 500);
    check("rr_reached_addr7", rom_addr, 7);
    rst = 1'b1; beat = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; beat = 1'b0; play = 1'b0;
    check("rr_addr", rom_addr, 0);
    check("rr_note", note_out, 0);
    check("rr_new", new_note, 0);
    check("rr_done", song_done, 0);
    play = 1'b1;
    wait_new_note(20, edges);
    check("rr_refetch_latency", edges, 3);
    check("rr_refetch_value", note_out, 1);
    check("rr_refetch_addr", rom_addr, 0);
    play = 1'b0;

    // Random songs with random beats and pauses
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_note[i] = NOTE_W'($urandom_range(0, 63));
        mem_dur[i]  = ($urandom_range(0, 19) == 0) ? 6'd0 : DUR_W'($urandom_range(1, 3));
      end
      run_song(0, 0, 80);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
